// File: rtl/paint_grid_pkg.sv
// Shared definitions for the paint grid tracker.
//   - pen encodings driven on the two-bit pen input
//   - bit positions of the four push buttons in btn[3:0]
//   - controller state type (sweep-clearing vs. normal operation)
package paint_grid_pkg;

    // Pen command encodings; 2'b11 is treated the same as PEN_NONE.
    localparam logic [1:0] PEN_NONE  = 2'b00;
    localparam logic [1:0] PEN_PAINT = 2'b01;
    localparam logic [1:0] PEN_ERASE = 2'b10;

    // Button bit positions, listed from highest to lowest move priority.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

    // ST_CLEAR zeroes one grid row per cycle; ST_IDLE accepts pen and moves.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } grid_state_t;

endpackage

// File: rtl/paint_grid_tracker_btn_edge_mover.sv
// Cursor mover: detects rising edges on the four level buttons and moves the
// cursor by one cell, with right > left > up > down priority (only the
// highest-priority edge in a cycle is used, the rest are discarded).
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   en                moves are applied only while high; edges seen while low
//                     are dropped, but the button history still follows btn
//   btn[3:0]          level buttons {down, up, left, right}
//   cur_col, cur_row  registered cursor position, row 0 = top
module btn_edge_mover
    import paint_grid_pkg::*;
#(
    parameter int HCELLS = 96,
    parameter int VCELLS = 54,
    parameter int WRAP   = 0,
    localparam int COL_W = $clog2(HCELLS),
    localparam int ROW_W = $clog2(VCELLS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [3:0]       btn,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(HCELLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(VCELLS - 1);

    logic [3:0]       btn_q;
    logic [3:0]       btn_evt;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_q   <= '0;
            cur_col <= '0;
            cur_row <= '0;
        end else begin
            btn_q   <= btn;
            cur_col <= col_d;
            cur_row <= row_d;
        end
    end

    // At an edge the cursor either wraps to the opposite edge or holds.
    always_comb begin
        btn_evt = btn & ~btn_q;
        col_d   = cur_col;
        row_d   = cur_row;
        if (en) begin
            if (btn_evt[BTN_RIGHT]) begin
                if (cur_col == COL_MAX) begin
                    if (WRAP != 0) col_d = '0;
                end else begin
                    col_d = cur_col + COL_W'(1);
                end
            end else if (btn_evt[BTN_LEFT]) begin
                if (cur_col == '0) begin
                    if (WRAP != 0) col_d = COL_MAX;
                end else begin
                    col_d = cur_col - COL_W'(1);
                end
            end else if (btn_evt[BTN_UP]) begin
                if (cur_row == '0) begin
                    if (WRAP != 0) row_d = ROW_MAX;
                end else begin
                    row_d = cur_row - ROW_W'(1);
                end
            end else if (btn_evt[BTN_DOWN]) begin
                if (cur_row == ROW_MAX) begin
                    if (WRAP != 0) row_d = '0;
                end else begin
                    row_d = cur_row + ROW_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/paint_grid_tracker.sv
// Cursor-driven paint grid for the VGA overlay path.
// A HCELLS x VCELLS bitmap is painted/erased at the cursor cell and read back
// per pixel for the display mixer. The painted-cell count is maintained
// incrementally on each pen write instead of being summed over the array.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   btn[3:0]     level buttons {down, up, left, right}
//   pen[1:0]     00 none, 01 paint, 10 erase, 11 none
//   clear        request a full grid clear (level, sampled every cycle)
//   pix_x/pix_y  current pixel coordinate
//   on           painted bit for the pixel's cell (1-cycle latency, 0 while busy)
//   cursor_hit   pixel lies in the cursor cell (1-cycle latency)
//   busy         clear sweep in progress
//   cur_col/row  cursor position, row 0 = top
//   cell_cnt     number of painted cells
//   pixel_cnt    cell_cnt * CELL_W * CELL_H, registered
//   dbg_state    controller state, for observation only
module paint_grid_tracker
    import paint_grid_pkg::*;
#(
    parameter int HCELLS = 96,
    parameter int VCELLS = 54,
    parameter int CELL_W = 5,
    parameter int CELL_H = 5,
    parameter int WRAP   = 0,
    parameter int CNT_W  = 17,
    localparam int COL_W  = $clog2(HCELLS),
    localparam int ROW_W  = $clog2(VCELLS),
    localparam int CCNT_W = $clog2(HCELLS * VCELLS + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        btn,
    input  logic [1:0]        pen,
    input  logic              clear,
    input  logic [13:0]       pix_x,
    input  logic [13:0]       pix_y,
    output logic              on,
    output logic              cursor_hit,
    output logic              busy,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic [CCNT_W-1:0] cell_cnt,
    output logic [CNT_W-1:0]  pixel_cnt,
    output grid_state_t       dbg_state
);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(VCELLS - 1);
    localparam int               CELL_AREA = CELL_W * CELL_H;

    grid_state_t       state_q, state_d;
    logic [ROW_W-1:0]  row_ptr_q, row_ptr_d;
    logic [CCNT_W-1:0] cnt_q, cnt_d;
    logic              sweep_we;
    logic              pen_we;
    logic              pen_val;
    logic              cur_cell;

    // Row-addressed bitmap: the sweep zeroes a whole row per cycle.
    logic [HCELLS-1:0] grid [VCELLS];

    assign busy      = (state_q == ST_CLEAR);
    assign cell_cnt  = cnt_q;
    assign dbg_state = state_q;
    assign cur_cell  = grid[cur_row][cur_col];

    // Cursor movement; button edges are only honoured outside the sweep.
    btn_edge_mover #(
        .HCELLS (HCELLS),
        .VCELLS (VCELLS),
        .WRAP   (WRAP)
    ) u_mover (
        .CLK     (CLK),
        .RESET   (RESET),
        .en      (state_q == ST_IDLE),
        .btn     (btn),
        .cur_col (cur_col),
        .cur_row (cur_row)
    );

    // Controller state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_CLEAR;
            row_ptr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_ptr_q <= row_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and pen decode. The pen uses the registered cursor, so a
    // move in the same cycle never redirects the write. A paint only counts
    // when the cell was empty and an erase only when it was set, which keeps
    // cnt_q bounded by the cell count without any saturation logic.
    always_comb begin
        state_d   = state_q;
        row_ptr_d = row_ptr_q;
        cnt_d     = cnt_q;
        sweep_we  = 1'b0;
        pen_we    = 1'b0;
        pen_val   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we = 1'b1;
                cnt_d    = '0;
                if (clear) begin
                    row_ptr_d = '0;
                end else if (row_ptr_q == ROW_LAST) begin
                    state_d   = ST_IDLE;
                    row_ptr_d = '0;
                end else begin
                    row_ptr_d = row_ptr_q + ROW_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    row_ptr_d = '0;
                    cnt_d     = '0;
                end else if (pen == PEN_PAINT && !cur_cell) begin
                    pen_we  = 1'b1;
                    pen_val = 1'b1;
                    cnt_d   = cnt_q + CCNT_W'(1);
                end else if (pen == PEN_ERASE && cur_cell) begin
                    pen_we  = 1'b1;
                    pen_val = 1'b0;
                    cnt_d   = cnt_q - CCNT_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Bitmap storage has no reset: every reset starts a sweep that zeroes
    // it, and 'on' is masked until the sweep completes.
    always_ff @(posedge CLK) begin
        if (sweep_we) begin
            grid[row_ptr_q] <= '0;
        end else if (pen_we && !RESET) begin
            grid[cur_row][cur_col] <= pen_val;
        end
    end

    // Pixel lookup: cell coordinates by constant division.
    logic [13:0] pix_col;
    logic [13:0] pix_row;
    logic        pix_in_grid;
    logic        pix_cell;

    always_comb begin
        pix_col     = pix_x / 14'(CELL_W);
        pix_row     = pix_y / 14'(CELL_H);
        pix_in_grid = (pix_col < 14'(HCELLS)) && (pix_row < 14'(VCELLS));
        pix_cell    = grid[pix_row[ROW_W-1:0]][pix_col[COL_W-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            on         <= 1'b0;
            cursor_hit <= 1'b0;
            pixel_cnt  <= '0;
        end else begin
            on         <= pix_in_grid && !busy && pix_cell;
            cursor_hit <= pix_in_grid
                          && (pix_col[COL_W-1:0] == cur_col)
                          && (pix_row[ROW_W-1:0] == cur_row);
            pixel_cnt  <= CNT_W'(32'(cnt_q) * 32'(CELL_AREA));
        end
    end

endmodule

// File: tb/tb_paint_grid_tracker.sv
// Bench for paint_grid_tracker: a bounded instance (WRAP=0) carries the
// painting scenarios, a wrapping instance (WRAP=1) checks wrap-around moves.
// A cycle-level reference model tracks cursor, bitmap and counts.
module tb_paint_grid_tracker;
    import paint_grid_pkg::*;

    localparam int H  = 96;
    localparam int V  = 54;
    localparam int CW = 5;
    localparam int CH = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  btn, btn1;
    logic [1:0]  pen;
    logic [1:0]  pen1;
    logic        clear;
    logic [13:0] pix_x, pix_y;

    logic        on, cursor_hit, busy;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic [12:0] cell_cnt;
    logic [16:0] pixel_cnt;
    grid_state_t dbg_state;

    logic        on1, cursor_hit1, busy1;
    logic [6:0]  cur_col1;
    logic [5:0]  cur_row1;
    logic [12:0] cell_cnt1;
    logic [16:0] pixel_cnt1;
    grid_state_t dbg_state1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    paint_grid_tracker #(.WRAP(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .btn(btn), .pen(pen), .clear(clear),
        .pix_x(pix_x), .pix_y(pix_y), .on(on), .cursor_hit(cursor_hit),
        .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
        .cell_cnt(cell_cnt), .pixel_cnt(pixel_cnt), .dbg_state(dbg_state)
    );

    paint_grid_tracker #(.WRAP(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .btn(btn1), .pen(pen1), .clear(clear),
        .pix_x(pix_x), .pix_y(pix_y), .on(on1), .cursor_hit(cursor_hit1),
        .busy(busy1), .cur_col(cur_col1), .cur_row(cur_row1),
        .cell_cnt(cell_cnt1), .pixel_cnt(pixel_cnt1), .dbg_state(dbg_state1)
    );

    // ---------------- reference model ----------------
    int       m_sweep;          // remaining busy cycles
    int       m_col [2];
    int       m_row [2];
    logic [3:0] m_prev [2];
    bit       m_grid [V][H];
    int       m_cnt;
    int       m_pixcnt;
    bit       m_on, m_hit;

    function automatic void model_wipe();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                m_grid[r][c] = 1'b0;
    endfunction

    function automatic void model_move(int k, logic [3:0] b, bit wrap, bit blocked);
        logic [3:0] ev;
        ev = b & ~m_prev[k];
        m_prev[k] = b;
        if (blocked) return;
        if (ev[0])
            m_col[k] = wrap ? (m_col[k] + 1) % H : ((m_col[k] + 1 > H - 1) ? H - 1 : m_col[k] + 1);
        else if (ev[1])
            m_col[k] = wrap ? (m_col[k] + H - 1) % H : ((m_col[k] == 0) ? 0 : m_col[k] - 1);
        else if (ev[2])
            m_row[k] = wrap ? (m_row[k] + V - 1) % V : ((m_row[k] == 0) ? 0 : m_row[k] - 1);
        else if (ev[3])
            m_row[k] = wrap ? (m_row[k] + 1) % V : ((m_row[k] + 1 > V - 1) ? V - 1 : m_row[k] + 1);
    endfunction

    // Called once per rising edge with the inputs the DUT samples there.
    function automatic void model_step();
        int c, r;
        bit ing, busy_now;
        if (RESET) begin
            m_sweep = V;
            for (int k = 0; k < 2; k++) begin
                m_col[k] = 0; m_row[k] = 0; m_prev[k] = 4'b0;
            end
            m_cnt = 0; m_pixcnt = 0; m_on = 0; m_hit = 0;
            model_wipe();
            return;
        end
        busy_now = (m_sweep > 0);
        c = int'(pix_x) / CW;
        r = int'(pix_y) / CH;
        ing = (c < H) && (r < V);
        m_on  = ing ? (!busy_now && m_grid[r][c]) : 1'b0;
        m_hit = ing && (c == m_col[0]) && (r == m_row[0]);
        m_pixcnt = m_cnt * CW * CH;
        if (!busy_now && !clear) begin
            if (pen == PEN_PAINT && !m_grid[m_row[0]][m_col[0]]) begin
                m_grid[m_row[0]][m_col[0]] = 1'b1; m_cnt++;
            end else if (pen == PEN_ERASE && m_grid[m_row[0]][m_col[0]]) begin
                m_grid[m_row[0]][m_col[0]] = 1'b0; m_cnt--;
            end
        end
        model_move(0, btn, 1'b0, busy_now);
        model_move(1, btn1, 1'b1, busy_now);
        if (clear) begin
            m_sweep = V; m_cnt = 0; model_wipe();
        end else if (busy_now) begin
            m_sweep--;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic press(int k, int b);
        if (k == 0) btn[b] = 1'b1; else btn1[b] = 1'b1;
        step();
        if (k == 0) btn = 4'b0; else btn1 = 4'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        RESET = 1'b1; btn = 0; btn1 = 0; pen = PEN_NONE; pen1 = PEN_NONE;
        clear = 1'b0; pix_x = 0; pix_y = 0;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b want 1", busy); end
        n_checks++; if (dbg_state !== ST_CLEAR) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_CLEAR); end
        n_checks++; if (on !== 1'b0 || cursor_hit !== 1'b0) begin n_fail++; $display("FAIL reset_on_hit: got %0b/%0b want 0/0", on, cursor_hit); end
        n_checks++; if (cur_col !== 7'd0 || cur_row !== 6'd0) begin n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
        n_checks++; if (cell_cnt !== 13'd0 || pixel_cnt !== 17'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", cell_cnt, pixel_cnt); end
        RESET = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
        n_checks++; if (n != V) begin n_fail++; $display("FAIL reset_busy_len: got %0d cycles want %0d", n, V); end
        for (int i = 0; i < 40; i++) begin
            pix_x = 14'($urandom_range(0, H * CW - 1));
            pix_y = 14'($urandom_range(0, V * CH - 1));
            step();
            n_checks++; if (on !== 1'b0) begin n_fail++; $display("FAIL reset_on_scan: (%0d,%0d) got %0b want 0", pix_x, pix_y, on); end
        end
    endtask

    task automatic test_bounded_moves();
        for (int i = 0; i < 100; i++) press(0, BTN_RIGHT);
        n_checks++; if (cur_col !== 7'd95) begin n_fail++; $display("FAIL bounded_right: got %0d want 95", cur_col); end
        press(0, BTN_UP);
        n_checks++; if (cur_row !== 6'd0) begin n_fail++; $display("FAIL bounded_up: got %0d want 0", cur_row); end
        n_checks++; if (cur_col1 !== 7'd0) begin n_fail++; $display("FAIL wrap_inst_idle: got %0d want 0", cur_col1); end
    endtask

    task automatic test_wrap_moves();
        press(1, BTN_LEFT);
        n_checks++; if (cur_col1 !== 7'd95) begin n_fail++; $display("FAIL wrap_left: got %0d want 95", cur_col1); end
        for (int i = 0; i < V - 1; i++) press(1, BTN_DOWN);
        n_checks++; if (cur_row1 !== 6'd53) begin n_fail++; $display("FAIL wrap_down_walk: got %0d want 53", cur_row1); end
        press(1, BTN_DOWN);
        n_checks++; if (cur_row1 !== 6'd0) begin n_fail++; $display("FAIL wrap_down: got %0d want 0", cur_row1); end
    endtask

    task automatic test_paint();
        for (int i = 0; i < 93; i++) press(0, BTN_LEFT);
        for (int i = 0; i < 3; i++) press(0, BTN_DOWN);
        n_checks++; if (cur_col !== 7'd2 || cur_row !== 6'd3) begin n_fail++; $display("FAIL paint_pos: got (%0d,%0d) want (2,3)", cur_col, cur_row); end
        pen = PEN_PAINT;
        step();
        n_checks++; if (cell_cnt !== 13'd1 || pixel_cnt !== 17'd0) begin n_fail++; $display("FAIL paint_latency: got %0d/%0d want 1/0", cell_cnt, pixel_cnt); end
        for (int i = 0; i < 9; i++) step();
        pen = PEN_NONE;
        n_checks++; if (cell_cnt !== 13'd1 || pixel_cnt !== 17'd25) begin n_fail++; $display("FAIL paint_hold: got %0d/%0d want 1/25", cell_cnt, pixel_cnt); end
        pix_x = 14'd12; pix_y = 14'd17;
        step();
        n_checks++; if (on !== 1'b1 || cursor_hit !== 1'b1) begin n_fail++; $display("FAIL paint_lookup: got %0b/%0b want 1/1", on, cursor_hit); end
        pix_x = 14'd17;
        step();
        n_checks++; if (on !== 1'b0 || cursor_hit !== 1'b0) begin n_fail++; $display("FAIL paint_neighbour: got %0b/%0b want 0/0", on, cursor_hit); end
    endtask

    task automatic test_erase();
        press(0, BTN_RIGHT); pen = PEN_PAINT; step(); pen = PEN_NONE;
        press(0, BTN_RIGHT); pen = PEN_PAINT; step();
        n_checks++; if (cell_cnt !== 13'd3) begin n_fail++; $display("FAIL erase_three: got %0d want 3", cell_cnt); end
        pen = PEN_ERASE; step(); pen = PEN_NONE;
        press(0, BTN_RIGHT);
        pen = PEN_ERASE; step(); pen = PEN_NONE;
        step();
        n_checks++; if (cell_cnt !== 13'd2 || pixel_cnt !== 17'd50) begin n_fail++; $display("FAIL erase_counts: got %0d/%0d want 2/50", cell_cnt, pixel_cnt); end
        btn = 4'b0101; step(); btn = 4'b0; step();
        n_checks++; if (cur_col !== 7'd6 || cur_row !== 6'd3) begin n_fail++; $display("FAIL right_up_priority: got (%0d,%0d) want (6,3)", cur_col, cur_row); end
        pen = PEN_PAINT; btn = 4'b0001; step();
        pen = PEN_NONE; btn = 4'b0; step();
        n_checks++; if (cur_col !== 7'd7 || cell_cnt !== 13'd3) begin n_fail++; $display("FAIL move_with_pen: got col %0d cnt %0d want 7/3", cur_col, cell_cnt); end
        pix_x = 14'd32; pix_y = 14'd17; step();
        n_checks++; if (on !== 1'b1 || cursor_hit !== 1'b0) begin n_fail++; $display("FAIL pre_move_cell: got %0b/%0b want 1/0", on, cursor_hit); end
        pix_x = 14'd37; step();
        n_checks++; if (on !== 1'b0 || cursor_hit !== 1'b1) begin n_fail++; $display("FAIL post_move_cell: got %0b/%0b want 0/1", on, cursor_hit); end
    endtask

    task automatic test_clear();
        int n;
        clear = 1'b1; step(); clear = 1'b0;
        n_checks++; if (cell_cnt !== 13'd0) begin n_fail++; $display("FAIL clear_cnt: got %0d want 0", cell_cnt); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            btn = 4'($urandom_range(0, 15));
            pix_x = 14'($urandom_range(0, 20));
            pix_y = 14'($urandom_range(10, 20));
            step();
            n_checks++; if (on !== m_on || m_on !== 1'b0) begin n_fail++; $display("FAIL clear_on_masked: got %0b want 0", on); end
        end
        btn = 4'b0;
        n_checks++; if (n != V) begin n_fail++; $display("FAIL clear_busy_len: got %0d cycles want %0d", n, V); end
        step(); step();
        n_checks++; if (cur_col !== 7'd7 || cur_row !== 6'd3) begin n_fail++; $display("FAIL clear_cursor: got (%0d,%0d) want (7,3)", cur_col, cur_row); end
        n_checks++; if (cell_cnt !== 13'd0 || pixel_cnt !== 17'd0) begin n_fail++; $display("FAIL clear_counts: got %0d/%0d want 0/0", cell_cnt, pixel_cnt); end
        pix_x = 14'd12; pix_y = 14'd17; step();
        n_checks++; if (on !== 1'b0) begin n_fail++; $display("FAIL clear_cell_gone: got %0b want 0", on); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            RESET = ($urandom_range(0, 599) == 0);
            clear = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 2) == 0) btn  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) btn1 = 4'($urandom_range(0, 15));
            pen   = 2'($urandom_range(0, 3));
            pix_x = 14'($urandom_range(0, 499));
            pix_y = 14'($urandom_range(0, 289));
            step();
            n_checks++; if (busy !== (m_sweep > 0)) begin n_fail++; $display("FAIL rnd_busy @%0d: got %0b want %0b", i, busy, m_sweep > 0); end
            n_checks++; if (on !== m_on) begin n_fail++; $display("FAIL rnd_on @%0d: got %0b want %0b", i, on, m_on); end
            n_checks++; if (cursor_hit !== m_hit) begin n_fail++; $display("FAIL rnd_hit @%0d: got %0b want %0b", i, cursor_hit, m_hit); end
            n_checks++; if (int'(cur_col) != m_col[0] || int'(cur_row) != m_row[0]) begin n_fail++; $display("FAIL rnd_cursor @%0d: got (%0d,%0d) want (%0d,%0d)", i, cur_col, cur_row, m_col[0], m_row[0]); end
            n_checks++; if (int'(cell_cnt) != m_cnt) begin n_fail++; $display("FAIL rnd_cell_cnt @%0d: got %0d want %0d", i, cell_cnt, m_cnt); end
            n_checks++; if (int'(pixel_cnt) != m_pixcnt) begin n_fail++; $display("FAIL rnd_pixel_cnt @%0d: got %0d want %0d", i, pixel_cnt, m_pixcnt); end
            n_checks++; if (int'(cur_col1) != m_col[1] || int'(cur_row1) != m_row[1]) begin n_fail++; $display("FAIL rnd_wrap_cursor @%0d: got (%0d,%0d) want (%0d,%0d)", i, cur_col1, cur_row1, m_col[1], m_row[1]); end
        end
        RESET = 1'b0; clear = 1'b0; btn = 0; btn1 = 0; pen = PEN_NONE;
    endtask

    initial begin
        test_reset();
        test_bounded_moves();
        test_wrap_moves();
        test_paint();
        test_erase();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
